// File: rtl/adder_pkg.sv
// ============================================================================
// Module      : adder_pkg
// Description : Shared types, limits and configuration check for the
//               pipelined add/subtract unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    localparam int MAX_STAGES = 4;

    function automatic bit cfg_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= MAX_STAGES) && (width > 0)
               && ((width % stages) == 0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/adder_segment.sv
// ============================================================================
// Module      : adder_segment
// Description : One SEG-bit adder slice with registered sum, carry and valid.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_segment #(
    parameter int SEG = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_load,
    input  logic           i_valid,
    input  logic [SEG-1:0] i_a,
    input  logic [SEG-1:0] i_b,
    input  logic           i_cin,
    output logic [SEG-1:0] o_sum,
    output logic           o_cout,
    output logic           o_valid
);

    logic [SEG:0]   w_full;
    logic [SEG-1:0] r_sum;
    logic           r_cout;
    logic           r_valid;

    assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{SEG{1'b0}}, i_cin};

    // Data only moves when a real item is loaded, so the outputs stay put otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_sum  <= w_full[SEG-1:0];
                r_cout <= w_full[SEG];
            end
        end
    end

    assign o_sum   = r_sum;
    assign o_cout  = r_cout;
    assign o_valid = r_valid;

endmodule

`default_nettype wire

// File: rtl/pipelined_adder.sv
// ============================================================================
// Module      : pipelined_adder
// Description : Segmented, carry-pipelined add/subtract with valid/ready.
//               Define ADDER_FLAGS_EN to add the carry_out/overflow ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
`ifdef ADDER_FLAGS_EN
    ,
    output logic             carry_out,
    output logic             overflow
`endif
);

    localparam int c_seg  = WIDTH / STAGES;
    localparam int c_last = STAGES - 1;

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
        $error("pipelined_adder: WIDTH must be divisible by STAGES, STAGES in 1..4");
    end

    logic              w_sub;
    logic [WIDTH-1:0]  w_bp;
    logic [STAGES-1:0] w_v;
    logic [STAGES-1:0] w_vin;
    logic [STAGES-1:0] w_cin;
    logic [STAGES-1:0] w_cout;
    logic [STAGES-1:0] w_adv;
    logic [STAGES-1:0] w_load;
    logic [c_seg-1:0]  w_sum   [STAGES];
    logic [WIDTH-1:0]  w_opa   [STAGES];
    logic [WIDTH-1:0]  w_opb   [STAGES];
    logic [WIDTH-1:0]  w_lo_in [STAGES];
    logic [WIDTH-1:0]  r_a     [STAGES];
    logic [WIDTH-1:0]  r_b     [STAGES];
    logic [WIDTH-1:0]  r_lo    [STAGES];
`ifdef ADDER_FLAGS_EN
    logic [STAGES-1:0] w_sa_in;
    logic [STAGES-1:0] w_sb_in;
    logic [STAGES-1:0] r_sa;
    logic [STAGES-1:0] r_sb;
`endif

    assign w_sub = (op == OP_SUB);
    assign w_bp  = w_sub ? ~b : b;

    // Backpressure ripples from out_ready towards the input; empty stages always load.
    always_comb begin
        logic go;
        w_adv  = '0;
        w_load = '0;
        go     = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_adv[k]  = w_v[k] && go;
            w_load[k] = !w_v[k] || (w_v[k] && go);
            go        = !w_v[k] || (w_v[k] && go);
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign w_vin[k]   = in_valid;
            assign w_opa[k]   = a;
            assign w_opb[k]   = w_bp;
            assign w_cin[k]   = w_sub;
            assign w_lo_in[k] = '0;
`ifdef ADDER_FLAGS_EN
            assign w_sa_in[k] = a[WIDTH-1];
            assign w_sb_in[k] = w_bp[WIDTH-1];
`endif
        end else begin : g_next
            assign w_vin[k]   = w_v[k-1];
            assign w_opa[k]   = r_a[k-1];
            assign w_opb[k]   = r_b[k-1];
            assign w_cin[k]   = w_cout[k-1];
            assign w_lo_in[k] = r_lo[k-1] | (WIDTH'(w_sum[k-1]) << ((k - 1) * c_seg));
`ifdef ADDER_FLAGS_EN
            assign w_sa_in[k] = r_sa[k-1];
            assign w_sb_in[k] = r_sb[k-1];
`endif
        end

        adder_segment #(
            .SEG (c_seg)
        ) u_seg (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_load  (w_load[k]),
            .i_valid (w_vin[k]),
            .i_a     (w_opa[k][k*c_seg +: c_seg]),
            .i_b     (w_opb[k][k*c_seg +: c_seg]),
            .i_cin   (w_cin[k]),
            .o_sum   (w_sum[k]),
            .o_cout  (w_cout[k]),
            .o_valid (w_v[k])
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_lo[k] <= '0;
            end else if (w_load[k] && w_vin[k]) begin
                r_lo[k] <= w_lo_in[k];
            end
        end

        // Operand bits still to be summed travel with the item; the last stage needs none.
        if (k < c_last) begin : g_pass
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a[k] <= '0;
                    r_b[k] <= '0;
                end else if (w_load[k] && w_vin[k]) begin
                    r_a[k] <= w_opa[k];
                    r_b[k] <= w_opb[k];
                end
            end
        end

`ifdef ADDER_FLAGS_EN
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sa[k] <= 1'b0;
                r_sb[k] <= 1'b0;
            end else if (w_load[k] && w_vin[k]) begin
                r_sa[k] <= w_sa_in[k];
                r_sb[k] <= w_sb_in[k];
            end
        end
`endif
    end

    assign in_ready  = w_load[0];
    assign out_valid = w_v[c_last];
    assign result    = r_lo[c_last] | (WIDTH'(w_sum[c_last]) << (c_last * c_seg));

`ifdef ADDER_FLAGS_EN
    assign carry_out = w_cout[c_last];
    assign overflow  = (r_sa[c_last] == r_sb[c_last]) && (result[WIDTH-1] != r_sa[c_last]);
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipelined_adder.sv
// ============================================================================
// Module      : tb_pipelined_adder
// Description : Scoreboard bench for pipelined_adder (WIDTH=64, STAGES=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipelined_adder;
    import adder_pkg::*;

    localparam int W = 64;
    localparam int S = 2;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         v;
    } exp_t;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    op_t          op        = OP_ADD;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
`ifdef ADDER_FLAGS_EN
    logic         carry_out;
    logic         overflow;
`endif

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    pipelined_adder #(
        .WIDTH  (W),
        .STAGES (S)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
`ifdef ADDER_FLAGS_EN
        ,
        .carry_out (carry_out),
        .overflow  (overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] r, input logic c, input logic v);
        exp_t e;
        e.res = r;
        e.c   = c;
        e.v   = v;
        return e;
    endfunction

    // Present one operand pair and hold it until accepted; the expectation is queued on acceptance.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_val, input op_t top,
                        input exp_t e);
        int n;
        n        = 0;
        a        = ta;
        b        = tb_val;
        op       = top;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed %b, expected 1", in_ready);
        end else begin
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("drain_pending", W'(q.size()), '0);
        #1;
    endtask

    // Monitor: pops one expectation per output transfer and watches stalled outputs for stability.
    logic         held_v = 1'b0;
    logic [W-1:0] held_res = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            if (held_v && out_valid) check("stall_hold", result, held_res);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got result %h, expected no output", result);
                end else begin
                    e = q.pop_front();
                    check("result", result, e.res);
`ifdef ADDER_FLAGS_EN
                    check("carry_out", W'(carry_out), W'(e.c));
                    check("overflow", W'(overflow), W'(e.v));
`endif
                end
            end
            held_v   = out_valid && !out_ready;
            held_res = result;
        end
    end

    initial begin
        int lat;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", W'(out_valid), '0);
        check("reset_result", result, '0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", W'(in_ready), W'(1));
        @(posedge clk);
        #1;

        // Carry crosses the segment boundary; also measures latency on an idle pipeline.
        out_ready = 1'b1;
        send(64'h0000_0000_FFFF_FFFF, 64'h1, OP_ADD, mk(64'h0000_0001_0000_0000, 1'b0, 1'b0));
        lat = 0;
        for (int k = 1; k <= S + 2; k++) begin
            @(negedge clk);
            if (out_valid && lat == 0) lat = k;
        end
        check("latency", W'(lat), W'(S));
        @(posedge clk);
        #1;

        send(64'd5, 64'd7, OP_SUB, mk(64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0));
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, OP_ADD, mk(64'h8000_0000_0000_0000, 1'b0, 1'b1));
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, OP_ADD, mk(64'h0, 1'b1, 1'b0));
        send(64'd7, 64'd5, OP_SUB, mk(64'd2, 1'b1, 1'b0));
        send(64'h8000_0000_0000_0000, 64'h1, OP_SUB, mk(64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1));
        send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, OP_ADD,
             mk(64'h2222_2222_2222_2211, 1'b0, 1'b0));
        drain();

        // Six back-to-back items with the consumer stalled for cycles 2..5.
        fork
            begin
                for (int i = 1; i <= 6; i++) send(W'(i), 64'd10, OP_ADD, mk(W'(10 + i), 1'b0, 1'b0));
            end
            begin
                out_ready = 1'b1;
                repeat (2) begin
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b0;
                repeat (2) begin
                    @(posedge clk);
                    #1;
                end
                @(negedge clk);
                check("stall_in_ready", W'(in_ready), '0);
                repeat (2) begin
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Two items in flight, then asynchronous reset discards them.
        out_ready = 1'b0;
        send(64'd100, 64'd1, OP_ADD, mk(64'd101, 1'b0, 1'b0));
        send(64'd200, 64'd1, OP_ADD, mk(64'd201, 1'b0, 1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        check("flush_out_valid", W'(out_valid), '0);
        check("flush_result", result, '0);
        q.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_reset_in_ready", W'(in_ready), W'(1));
        repeat (6) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
